alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl_if.sv | 54 +++++
 rtl/alu_seq_ctrl.sv | 93 +++++++++
 tb/tb_alu_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Request, ALU-drive, ALU-result and response signals of alu_seq_ctrl.
// The controller connects through the slave modport; the requester/ALU side uses master.
interface alu_seq_ctrl_if #(
  parameter int n = 32,
  parameter int m = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] in_a;
  logic [n-1:0] in_b;
  logic [m-1:0] in_sel;
  logic         in_cin;

  logic [n-1:0] alu_a;
  logic [n-1:0] alu_b;
  logic [m-1:0] alu_sel;
  logic         alu_cin;
  logic [n-1:0] alu_res;
  logic         alu_cout;
  logic         alu_neg;
  logic         alu_ovf;
  logic         alu_null;

  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_res;
  logic         out_cout;
  logic         out_neg;
  logic         out_ovf;
  logic         out_null;
  logic         out_err;

  logic [15:0]  op_count;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_cin,
    output in_ready,
    output alu_a, alu_b, alu_sel, alu_cin,
    input  alu_res, alu_cout, alu_neg, alu_ovf, alu_null,
    output out_valid, out_res, out_cout, out_neg, out_ovf, out_null, out_err,
    input  out_ready,
    output op_count
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, in_cin,
    input  in_ready,
    input  alu_a, alu_b, alu_sel, alu_cin,
    output alu_res, alu_cout, alu_neg, alu_ovf, alu_null,
    input  out_valid, out_res, out_cout, out_neg, out_ovf, out_null, out_err,
    output out_ready,
    input  op_count
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for an external combinational ALU: accepts one request,
// drives the ALU for one cycle, captures its result and holds it until accepted.
module alu_seq_ctrl #(
  parameter int n = 32,
  parameter int m = 4
) (
  input logic          clk,
  input logic          rst,
  alu_seq_ctrl_if.slave bus
);

  localparam int unsigned NUM_OPS = 9;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic   req_xfer;
  logic   rsp_xfer;
  logic   sel_legal;

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = EXEC;
      end
      EXEC: state_d = DONE;
      DONE: begin
        bus.in_ready  = bus.out_ready;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = bus.in_valid ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Held low throughout reset even though the state register already reads IDLE.
    if (rst) bus.in_ready = 1'b0;
  end

  assign req_xfer  = bus.in_valid & bus.in_ready;
  assign rsp_xfer  = bus.out_valid & bus.out_ready;
  assign sel_legal = (32'(bus.alu_sel) < NUM_OPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_sel  <= '0;
      bus.alu_cin  <= 1'b0;
      bus.out_res  <= '0;
      bus.out_cout <= 1'b0;
      bus.out_neg  <= 1'b0;
      bus.out_ovf  <= 1'b0;
      bus.out_null <= 1'b0;
      bus.out_err  <= 1'b0;
      bus.op_count <= '0;
    end else begin
      state_q <= state_d;
      if (req_xfer) begin
        bus.alu_a   <= bus.in_a;
        bus.alu_b   <= bus.in_b;
        bus.alu_sel <= bus.in_sel;
        bus.alu_cin <= bus.in_cin;
      end
      if (state_q == EXEC) begin
        if (sel_legal) begin
          bus.out_res  <= bus.alu_res;
          bus.out_cout <= bus.alu_cout;
          bus.out_neg  <= bus.alu_neg;
          bus.out_ovf  <= bus.alu_ovf;
          bus.out_null <= bus.alu_null;
          bus.out_err  <= 1'b0;
        end else begin
          bus.out_res  <= '0;
          bus.out_cout <= 1'b0;
          bus.out_neg  <= 1'b0;
          bus.out_ovf  <= 1'b0;
          bus.out_null <= 1'b0;
          bus.out_err  <= 1'b1;
        end
      end
      if (rsp_xfer) bus.op_count <= bus.op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a stub ALU, directed vector table, multi-cycle corner
// sequences and a randomized run scored against a transaction-level queue model.
module tb_alu_seq_ctrl;

  localparam int N = 32;
  localparam int M = 4;

  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic        neg;
    logic        ovf;
    logic        nul;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic        cin;
    rsp_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_cnt = '0;
  rsp_t q[$];
  vec_t vecs[14];

  alu_seq_ctrl_if #(.n(N), .m(M)) bus ();
  alu_seq_ctrl #(.n(N), .m(M)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Stub ALU; illegal codes produce junk so pass-through of them is visible.
  function automatic rsp_t alu_fn(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] sel, input logic cin);
    rsp_t        r;
    logic [32:0] w;
    r = '0;
    w = '0;
    case (sel)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b} + 33'(cin);
        r.res = w[31:0]; r.cout = w[32];
        r.ovf = (a[31] == b[31]) && (r.res[31] != a[31]);
      end
      4'd1: begin
        w = {1'b0, a} - {1'b0, b} - 33'(cin);
        r.res = w[31:0]; r.cout = w[32];
        r.ovf = (a[31] != b[31]) && (r.res[31] != a[31]);
      end
      4'd2: r.res = a & b;
      4'd3: r.res = a | b;
      4'd4: r.res = a ^ b;
      4'd5: r.res = a << b[4:0];
      4'd6: r.res = a >> b[4:0];
      4'd7: r.res = a <<< b[4:0];
      4'd8: r.res = 32'($signed(a) >>> b[4:0]);
      default: r = {32'hDEADBEEF, 5'b11110};
    endcase
    if (sel <= 4'd8) begin
      r.neg = r.res[31];
      r.nul = (r.res == 32'd0);
    end
    r.err = 1'b0;
    return r;
  endfunction

  function automatic rsp_t ref_rsp(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] sel, input logic cin);
    if (sel > 4'd8) return {32'd0, 5'b00001};
    return alu_fn(a, b, sel, cin);
  endfunction

  always_comb begin
    rsp_t r;
    r = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_cin);
    bus.alu_res  = r.res;
    bus.alu_cout = r.cout;
    bus.alu_neg  = r.neg;
    bus.alu_ovf  = r.ovf;
    bus.alu_null = r.nul;
  end

  function automatic rsp_t out_now();
    return {bus.out_res, bus.out_cout, bus.out_neg, bus.out_ovf, bus.out_null, bus.out_err};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] sel, input logic cin);
    bus.in_valid = v; bus.in_a = a; bus.in_b = b; bus.in_sel = sel; bus.in_cin = cin;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_op_count", 64'(bus.op_count), 64'd0);
    chk("rst_alu", {bus.alu_a, bus.alu_sel, bus.alu_cin, 27'd0}, 64'd0);
    chk("rst_out", 64'(out_now()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    #1;
    chk("rst_release_ready", 64'(bus.in_ready), 64'd1);
  endtask

  // One complete transaction with the response accepted in its first DONE cycle.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    chk($sformatf("v%0d_idle_ready", idx), 64'(bus.in_ready), 64'd1);
    drive(1'b1, v.a, v.b, v.sel, v.cin);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0);
    chk($sformatf("v%0d_exec", idx), {62'd0, bus.out_valid, bus.in_ready}, 64'd0);
    chk($sformatf("v%0d_alu_drive", idx), {bus.alu_a, bus.alu_b[26:0], bus.alu_sel, bus.alu_cin},
        {v.a, v.b[26:0], v.sel, v.cin});
    @(negedge clk);
    chk($sformatf("v%0d_valid", idx), 64'(bus.out_valid), 64'd1);
    chk($sformatf("v%0d_rsp", idx), 64'(out_now()), 64'(v.exp));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt++;
    chk($sformatf("v%0d_after", idx), {47'd0, bus.out_valid, bus.op_count},
        {47'd0, 1'b0, exp_cnt});
  endtask

  initial begin
    vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 4'd0, 1'b0, {32'h80000000, 5'b01100}};
    vecs[1]  = '{32'h00000005, 32'h00000005, 4'd1, 1'b0, {32'h00000000, 5'b00010}};
    vecs[2]  = '{32'hFFFFFFFF, 32'h00000000, 4'hF, 1'b0, {32'h00000000, 5'b00001}};
    vecs[3]  = '{32'hFFFFFFFF, 32'h00000001, 4'd0, 1'b0, {32'h00000000, 5'b10010}};
    vecs[4]  = '{32'hF0F0F0F0, 32'hFFFF0000, 4'd2, 1'b0, {32'hF0F00000, 5'b01000}};
    vecs[5]  = '{32'h0000FFFF, 32'h12340000, 4'd3, 1'b0, {32'h1234FFFF, 5'b00000}};
    vecs[6]  = '{32'hF0F0F0F0, 32'hFFFF0000, 4'd4, 1'b0, {32'h0F0FF0F0, 5'b00000}};
    vecs[7]  = '{32'h00000001, 32'h00000004, 4'd5, 1'b0, {32'h00000010, 5'b00000}};
    vecs[8]  = '{32'h80000000, 32'h0000001F, 4'd6, 1'b0, {32'h00000001, 5'b00000}};
    vecs[9]  = '{32'h80000000, 32'h00000004, 4'd8, 1'b0, {32'hF8000000, 5'b01000}};
    vecs[10] = '{32'h00000003, 32'h00000001, 4'd1, 1'b1, {32'h00000001, 5'b00000}};
    vecs[11] = '{32'h00000000, 32'h00000001, 4'd1, 1'b0, {32'hFFFFFFFF, 5'b11000}};
    vecs[12] = '{32'h12345678, 32'h87654321, 4'd9, 1'b1, {32'h00000000, 5'b00001}};
    vecs[13] = '{32'h40000000, 32'h00000001, 4'd7, 1'b0, {32'h80000000, 5'b01000}};

    drive(1'b0, '0, '0, '0, 1'b0);
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Backpressure: response held five cycles; a competing request must be ignored.
    do_reset();
    @(negedge clk);
    drive(1'b1, 32'h7FFFFFFF, 32'h1, 4'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h11111111, 32'h22222222, 4'd3, 1'b1);
      #1;
      chk($sformatf("bp%0d_state", i), {62'd0, bus.out_valid, bus.in_ready}, 64'd2);
      chk($sformatf("bp%0d_rsp", i), 64'(out_now()), 64'({32'h80000000, 5'b01100}));
      chk($sformatf("bp%0d_alu", i), {bus.alu_a, bus.alu_sel, 28'd0}, {32'h7FFFFFFF, 4'd0, 28'd0});
      @(negedge clk);
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_release", {46'd0, bus.out_valid, bus.in_ready, bus.op_count}, {46'd0, 2'b01, 16'd1});
    @(negedge clk);
    chk("bp_single", 64'(bus.op_count), 64'd1);

    // Back-to-back: new request accepted in the same cycle as the response.
    do_reset();
    @(negedge clk);
    drive(1'b1, 32'h00000002, 32'h00000003, 4'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    chk("b2b_first", 64'(out_now()), 64'({32'h00000005, 5'b00000}));
    drive(1'b1, 32'hF0F0F0F0, 32'hFFFF0000, 4'd4, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    chk("b2b_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0);
    bus.out_ready = 1'b0;
    chk("b2b_exec", {47'd0, bus.out_valid, bus.op_count}, {47'd0, 1'b0, 16'd1});
    @(negedge clk);
    chk("b2b_second", {27'd0, bus.out_valid, out_now()}, {27'd0, 1'b1, 32'h0F0FF0F0, 5'b00000});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("b2b_count", {47'd0, bus.out_valid, bus.op_count}, {47'd0, 1'b0, 16'd2});

    // Reset pulsed mid-EXEC drops the operation.
    do_reset();
    @(negedge clk);
    drive(1'b1, 32'h5, 32'h5, 4'd1, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("rexec_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rexec_quiet%0d", i), {47'd0, bus.out_valid, bus.op_count}, 64'd0);
    end
    bus.out_ready = 1'b0;

    // Randomized traffic scored against an expected-response queue.
    exp_cnt = bus.op_count;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [31:0] ra, rb;
      @(negedge clk);
      ra = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF << $urandom_range(0, 1) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'(ra) : $urandom;
      drive(1'($urandom_range(0, 1)), ra, rb, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_count", 64'(bus.op_count), 64'(exp_cnt));
      if (bus.out_valid) begin
        if (q.size() == 0) chk("rnd_spurious", 64'(bus.out_valid), 64'd0);
        else begin
          chk("rnd_rsp", 64'(out_now()), 64'(q[0]));
          if (bus.out_ready) begin
            void'(q.pop_front());
            exp_cnt++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(ref_rsp(bus.in_a, bus.in_b, bus.in_sel, bus.in_cin));
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && q.size() > 0; cyc++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) begin
        chk("drain_rsp", 64'(out_now()), 64'(q[0]));
        void'(q.pop_front());
        exp_cnt++;
      end
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    @(negedge clk);
    chk("final_count", 64'(bus.op_count), 64'(exp_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
